// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// stream_pkg -- shared stream constants, stb/ack transfer rule, clog2 helper
// Revision: 1.0
// ============================================================================
package stream_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // A word moves across an interface only on an edge where both are high.
    function automatic logic xfer(input logic stb, input logic ack);
        return stb & ack;
    endfunction

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_fifo_ram.sv
`default_nettype none
// ============================================================================
// stream_fifo_ram -- DEPTH x WIDTH storage, synchronous write, async read
// Revision: 1.0
// ============================================================================
module stream_fifo_ram
    import stream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      wr_en_i,
    input  logic [clog2(DEPTH)-1:0]   wr_addr_i,
    input  logic [WIDTH-1:0]          wr_data_i,
    input  logic [clog2(DEPTH)-1:0]   rd_addr_i,
    output logic [WIDTH-1:0]          rd_data_o
);

    // Contents are deliberately left unreset.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/stream_fifo.sv
`default_nettype none
// ============================================================================
// stream_fifo -- stb/ack stream FIFO; optional statistics via STREAM_FIFO_STATS_EN
// Revision: 1.0
// ============================================================================
module stream_fifo
    import stream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           input_a,
    input  logic                       input_a_stb,
    output logic                       input_a_ack,
    output logic [WIDTH-1:0]           output_z,
    output logic                       output_z_stb,
    input  logic                       output_z_ack,
    output logic [$clog2(DEPTH):0]     count
`ifdef STREAM_FIFO_STATS_EN
    ,
    output logic [31:0]                words_in,
    output logic [31:0]                words_out,
    output logic [$clog2(DEPTH):0]     max_count
`endif
);

    localparam int C_AW = clog2(DEPTH);
    localparam int C_CW = C_AW + 1;

    logic [C_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [C_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [C_CW-1:0] count_q, count_d;
    logic            w_push;
    logic            w_pop;

    // Handshake outputs come from registered occupancy only.
    assign input_a_ack  = (count_q != C_CW'(DEPTH));
    assign output_z_stb = (count_q != '0);
    assign count        = count_q;

    assign w_push = xfer(input_a_stb, input_a_ack);
    assign w_pop  = xfer(output_z_stb, output_z_ack);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + C_AW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_AW'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + C_CW'(1);
            2'b01:   count_d = count_q - C_CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    stream_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (w_push),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (input_a),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (output_z)
    );

`ifdef STREAM_FIFO_STATS_EN
    logic [31:0]     words_in_q;
    logic [31:0]     words_out_q;
    logic [C_CW-1:0] max_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            words_in_q  <= '0;
            words_out_q <= '0;
            max_count_q <= '0;
        end else begin
            if (w_push) begin
                words_in_q <= words_in_q + 32'd1;
            end
            if (w_pop) begin
                words_out_q <= words_out_q + 32'd1;
            end
            if (count_d > max_count_q) begin
                max_count_q <= count_d;
            end
        end
    end

    assign words_in  = words_in_q;
    assign words_out = words_out_q;
    assign max_count = max_count_q;
`endif

endmodule
`default_nettype wire
